// File: rtl/sequencer.sv
// rtl/sequencer.sv - nic8 instruction sequencer: fetch/execute, run/step/halt control and bus loan to the program loader.
module sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [14:0]        decoded,
  input  logic               isHalt,
  input  logic               run,
  input  logic               step,
  input  logic               busReq,
  output logic               busGrant,
  output logic [14:0]        controlBits,
  output logic               pcInc,
  output logic [1:0]         phase,
  output logic               halted,
  output logic [COUNT_W-1:0] instrCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    LOAN  = 2'b11
  } state_t;

  localparam logic [14:0] FETCH_CTRL = 15'h4080;

  state_t               state_q, state_d;
  logic                 step_pending_q, step_pending_d;
  logic                 halted_q, halted_d;
  logic                 grant_q, grant_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      step_pending_q <= 1'b0;
      halted_q       <= 1'b0;
      grant_q        <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      step_pending_q <= step_pending_d;
      halted_q       <= halted_d;
      grant_q        <= grant_d;
      count_q        <= count_d;
    end
  end

  // A step pulse is latched in every state; only the step-driven IDLE->FETCH consumes it.
  always_comb begin
    state_d        = state_q;
    step_pending_d = step_pending_q | step;
    halted_d       = halted_q;
    count_d        = count_q;
    case (state_q)
      IDLE: begin
        if (busReq) begin
          state_d = LOAN;
        end else if (step_pending_q || step) begin
          state_d        = FETCH;
          halted_d       = 1'b0;
          step_pending_d = 1'b0;
        end else if (run && !halted_q) begin
          state_d = FETCH;
        end
      end
      FETCH: state_d = EXEC;
      EXEC: begin
        count_d = count_q + COUNT_W'(1);
        if (isHalt) begin
          halted_d = 1'b1;
          state_d  = IDLE;
        end else if (busReq) begin
          state_d = LOAN;
        end else if (run && !step_pending_q) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      LOAN: begin
        if (!busReq) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    grant_d = (state_d == LOAN);
  end

  always_comb begin
    controlBits = '0;
    pcInc       = 1'b0;
    case (state_q)
      FETCH: begin
        controlBits = FETCH_CTRL;
        pcInc       = 1'b1;
      end
      EXEC: begin
        controlBits = decoded;
        pcInc       = decoded[3];
      end
      default: begin
        controlBits = '0;
        pcInc       = 1'b0;
      end
    endcase
  end

  assign phase      = state_q;
  assign busGrant   = grant_q;
  assign halted     = halted_q;
  assign instrCount = count_q;

endmodule

// File: tb/tb_sequencer.sv
// tb/tb_sequencer.sv - scoreboard bench for sequencer with a behavioural fetch/execute model.
module tb_sequencer;
  localparam int CW = 8;
  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_LOAN = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [14:0]   decoded = '0;
  logic          isHalt = 1'b0, run = 1'b0, step = 1'b0, busReq = 1'b0;
  logic          busGrant, pcInc, halted;
  logic [14:0]   controlBits;
  logic [1:0]    phase;
  logic [CW-1:0] instrCount;

  sequencer #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .decoded(decoded), .isHalt(isHalt), .run(run),
    .step(step), .busReq(busReq), .busGrant(busGrant), .controlBits(controlBits),
    .pcInc(pcInc), .phase(phase), .halted(halted), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ph;
    int cb;
    int pi;
    int bg;
    int hl;
    int cnt;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: which step of the instruction cycle we are in, plus flags.
  int m_ph, m_pend, m_halt, m_cnt;

  task automatic m_rst();
    m_ph = P_IDLE; m_pend = 0; m_halt = 0; m_cnt = 0;
  endtask

  task automatic m_adv();
    int nxt;
    int old_pend;
    old_pend = m_pend;
    nxt = m_ph;
    if (step) m_pend = 1;
    if (m_ph == P_IDLE) begin
      if (busReq) nxt = P_LOAN;
      else if (old_pend != 0 || step) begin
        nxt = P_FETCH; m_halt = 0; m_pend = 0;
      end else if (run && m_halt == 0) nxt = P_FETCH;
    end else if (m_ph == P_FETCH) begin
      nxt = P_EXEC;
    end else if (m_ph == P_EXEC) begin
      m_cnt = (m_cnt + 1) % (1 << CW);
      if (isHalt) begin
        m_halt = 1; nxt = P_IDLE;
      end else if (busReq) nxt = P_LOAN;
      else if (run && old_pend == 0) nxt = P_FETCH;
      else nxt = P_IDLE;
    end else begin
      if (!busReq) nxt = P_IDLE;
    end
    m_ph = nxt;
  endtask

  task automatic push();
    exp_t e;
    e.ph  = m_ph;
    e.cb  = (m_ph == P_FETCH) ? 'h4080 : (m_ph == P_EXEC) ? int'(decoded) : 0;
    e.pi  = (m_ph == P_FETCH) ? 1 : (m_ph == P_EXEC) ? int'(decoded[3]) : 0;
    e.bg  = (m_ph == P_LOAN) ? 1 : 0;
    e.hl  = m_halt;
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic drive(input logic rs, input logic rn, input logic st, input logic br,
                       input logic ih, input logic [14:0] dec);
    @(posedge clk);
    #1;
    if (!reset) m_rst();
    else m_adv();
    reset = rs; run = rn; step = st; busReq = br; isHalt = ih; decoded = dec;
    if (!rs) m_rst();
    push();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("phase", int'(phase), e.ph);
      chk("controlBits", int'(controlBits), e.cb);
      chk("pcInc", int'(pcInc), e.pi);
      chk("busGrant", int'(busGrant), e.bg);
      chk("halted", int'(halted), e.hl);
      chk("instrCount", int'(instrCount), e.cnt);
    end
  end

  initial begin
    logic br_r;
    m_rst();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 15'h0000);

    // Free run with loadA
    for (int i = 0; i < 12; i++) drive(1, 1, 0, 0, 0, 15'h1000);
    // Stop, then single step with a second pulse landing in EXEC
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 15'h1000);
    drive(1, 0, 1, 0, 0, 15'h1000);
    drive(1, 0, 0, 0, 0, 15'h1000);
    drive(1, 0, 1, 0, 0, 15'h1000);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0, 15'h1000);
    // Double pulse while idle collapses to one step
    drive(1, 0, 1, 1, 0, 15'h1000);
    drive(1, 0, 1, 0, 0, 15'h1000);
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, 0, 15'h1000);

    // Halt with run held, then a step restarts
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 1, 15'h0001);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 15'h1000);
    drive(1, 1, 1, 0, 0, 15'h1000);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 15'h1000);

    // Immediate operand vs plain
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 15'h1088);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 15'h1000);

    // Loan requested mid-instruction, released, run resumes
    for (int i = 0; i < 40 && m_ph != P_FETCH; i++) drive(1, 1, 0, 0, 0, 15'h1000);
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 1, 0, 15'h1000);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 15'h1000);

    // Counter at all ones, parked in LOAN, then async reset
    for (int i = 0; i < 2000 && !(m_ph == P_FETCH && m_cnt == (1 << CW) - 2); i++)
      drive(1, 1, 0, 0, 0, 15'h1000);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 1, 0, 15'h1000);
    drive(0, 1, 0, 1, 0, 15'h1000);
    drive(1, 1, 0, 0, 0, 15'h1000);

    // Long free run crosses the counter wrap
    for (int i = 0; i < 2 * (1 << CW) + 10; i++) drive(1, 1, 0, 0, 0, 15'h1000);

    // Randomised traffic
    br_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      logic rs, rn, st, ih;
      logic [14:0] dec;
      if ($urandom_range(0, 9) == 0) br_r = ~br_r;
      rs  = ($urandom_range(0, 199) != 0);
      rn  = ($urandom_range(0, 9) < 7);
      st  = ($urandom_range(0, 9) == 0);
      ih  = ($urandom_range(0, 19) == 0);
      dec = 15'($urandom);
      drive(rs, rn, st, br_r, ih, dec);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sequencer.md
# sequencer

Instruction sequencer for the nic8 datapath. It generates the 15-bit `Control` word that drives the register file, ALU and memory strobes. It runs the fetch/execute cycle, handles run/stop/single-step and halt instructions, and lends the memory bus to an external program loader through a request/grant handshake at instruction boundaries.

## Interface
Parameters:
- `COUNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `decoded`  in  15  control word for the current `ir`, from the decoder.
  - Bit order, MSB first: loadIR, loadPC, loadA, loadB, loadX, doOut, storeMem, assertM, assertE, assertA, assertX, immediate, jumpControl, doSubtract, doJump.
- `isHalt`  in  1  decoder flag: current `ir` is the halt instruction.
- `run`  in  1  level; 1 = free-run, 0 = stop at the next instruction boundary.
- `step`  in  1  one-cycle pulse requesting execution of exactly one instruction.
- `busReq`  in  1  loader requests the memory bus; level, held until done.
- `busGrant`  out  1  loader owns the bus.
- `controlBits`  out  15  `Control` word to the datapath.
- `pcInc`  out  1  advance PC at the end of this cycle.
- `phase`  out  2  current state encoding.
- `halted`  out  1  a halt instruction has retired.
- `instrCount`  out  `COUNT_W`  count of retired instructions.

## Operation
- States and `phase` encoding: IDLE=00, FETCH=01, EXEC=10, LOAN=11.
- `controlBits` and `pcInc` are combinational from the state and `decoded`. All other outputs are registered.
  - IDLE: `controlBits`=0, `pcInc`=0.
  - FETCH: `controlBits`=15'h4080 (loadIR and assertM only), `pcInc`=1.
  - EXEC: `controlBits`=`decoded`, `pcInc`=`decoded[3]` (immediate consumes an operand byte).
  - LOAN: `controlBits`=0, `pcInc`=0, `busGrant`=1.
- Step latch:
  - A `step` pulse seen in any state sets `stepPending`.
  - It is cleared when consumed, i.e. on the IDLE→FETCH transition caused by step.
  - A second pulse while pending is absorbed; at most one step is outstanding.
- IDLE transitions, in priority order:
  1. `busReq`=1 → LOAN.
  2. `stepPending` or `step`=1 → FETCH; clears `halted` and the latch.
  3. `run`=1 and `halted`=0 → FETCH.
  4. Otherwise stay in IDLE.
- FETCH transitions: always → EXEC next cycle. `busReq` is not honoured mid-instruction.
- EXEC transitions:
  - Always: `instrCount` increments, wrapping from all-ones to 0.
  - If `isHalt`=1: set `halted` and go to IDLE.
  - Else if `busReq`=1: go to LOAN.
  - Else if `run`=1 and no step is pending: go to FETCH.
  - Otherwise go to IDLE.
- LOAN transitions: stay while `busReq`=1; go to IDLE on the first cycle `busReq` is sampled 0.
- `halted` blocks `run` only. A step clears it and executes one instruction.

## Timing
- Reset, asynchronous, on the falling edge of `reset`:
  - State goes to IDLE.
  - `busGrant`=0, `halted`=0, `instrCount`=0, `stepPending`=0.
  - `controlBits`=0, `pcInc`=0, `phase`=00.
- Reset mid-operation (including during LOAN) aborts immediately. Outputs take reset values without waiting for a clock edge.
- One instruction takes two cycles: FETCH then EXEC. Back-to-back instructions run with no IDLE gap while `run`=1.
- Starting from IDLE, FETCH is the cycle after `run` or `step` is sampled high.
- Loan handshake:
  - `busGrant` rises at most 2 cycles after `busReq` from mid-instruction, or 1 cycle after from IDLE.
  - `busGrant` falls 1 cycle after `busReq` falls.
  - `busGrant` is never high in FETCH or EXEC.
- `run` dropping during FETCH still completes the EXEC that follows. The block then stops in IDLE.
- `instrCount` updates on the EXEC→next edge and is visible the following cycle.

## Test plan
- Free run: deassert `reset`, hold `run`=1, `decoded`=15'h1000 (loadA), `isHalt`=0 for 10 cycles.
  - Required: `phase` 00,01,10,01,10,…; FETCH cycles show 15'h4080 with `pcInc`=1; `instrCount`=4 after cycle 10.
- Single step: `run`=0, one `step` pulse.
  - Required: exactly one FETCH and one EXEC, then IDLE; `instrCount` goes from 0 to 1.
  - A pulse given during that EXEC leaves one pending step, which runs exactly one more instruction.
- Halt: `run`=1, `isHalt`=1 in EXEC.
  - Required: `halted`=1, block stays in IDLE with `run` still 1.
  - A `step` clears `halted` and runs one instruction.
- Loan: raise `busReq` during a FETCH.
  - Required: EXEC completes, LOAN is entered with `busGrant`=1 and `controlBits`=0.
  - Drop `busReq`: `busGrant`=0 one cycle later, then FETCH resumes with `run`=1.
- Async reset while in LOAN with `instrCount`=0xFFFF.
  - Required: immediate `busGrant`=0, `phase`=00, `instrCount`=0.
  - Separately: 0xFFFF plus one retire wraps to 0x0000.
- Immediate operand: `decoded`=15'h1088 (loadA, assertM, immediate) in EXEC.
  - Required: `pcInc`=1 in EXEC; with `decoded`=15'h1000, `pcInc`=0.
